// File: rtl/pll_phase_stepper_pkg.sv
// Shared definitions for the ECP5 EHXPLLL fine-phase stepper.
//  - state_e     : sequencer states
//  - SEL_*       : PHASESEL encodings of the four PLL outputs
//  - DIR_*       : PHASEDIR encodings (lag = +1 per step, lead = -1 per step)
//  - max_int     : elaboration-time helper for sizing the shared cycle counter
package pll_phase_stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_SETTLE,
        ST_WAIT_LOCK,
        ST_DONE
    } state_e;

    localparam logic [1:0] SEL_CLKOP  = 2'd0;
    localparam logic [1:0] SEL_CLKOS  = 2'd1;
    localparam logic [1:0] SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] SEL_CLKOS3 = 2'd3;

    localparam logic DIR_LAG  = 1'b0;
    localparam logic DIR_LEAD = 1'b1;

    localparam int NUM_OUTPUTS = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_phase_stepper_lock_sync_filter.sv
// Lock monitor: brings the asynchronous PLL LOCK into the fabric clock domain
// and counts consecutive cycles of synchronized lock.
// Ports:
//  clock, reset : fabric clock, synchronous active-high reset
//  async_in     : raw PLL LOCK
//  clr          : restart the consecutive-lock count
//  synced       : LOCK after a 2-FF synchronizer
//  stable       : synced has been high for LOCK_STABLE consecutive cycles
module lock_sync_filter #(
    parameter int LOCK_STABLE = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    input  logic clr,
    output logic synced,
    output logic stable
);

    localparam int CW = $clog2(LOCK_STABLE + 1);

    logic          meta;
    logic [CW-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so meta -> synced
    // forms two real flops instead of collapsing into one.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            count  <= '0;
        end else begin
            meta   <= async_in;
            synced <= meta;
            if (clr || !synced) begin
                count <= '0;
            end else if (count != CW'(LOCK_STABLE)) begin
                // Saturate so a long lock does not wrap back below threshold.
                count <= count + CW'(1);
            end
        end
    end

    assign stable = (count == CW'(LOCK_STABLE));

endmodule

// File: rtl/pll_phase_stepper.sv
// Sequencer for ECP5 EHXPLLL dynamic fine-phase adjust.
// Accepts "move output N by K steps in direction D" requests, drives
// PHASESEL/PHASEDIR setup, emits active-low PHASESTEP pulses, waits for
// re-lock and keeps a per-output phase offset table.
// Ports:
//  clock, reset      : fabric clock, synchronous active-high reset
//  req_valid/ready   : request handshake (ready only in IDLE, after done)
//  req_sel/dir/steps : target output, direction, number of steps
//  busy, done, err   : status; err qualifies the one-cycle done pulse
//  phase_pos         : packed per-output offsets, field i = [i*POS_W +: POS_W]
//  pll_locked        : raw PLL LOCK (asynchronous)
//  pll_phasesel/dir/step : to the EHXPLLL dynamic phase pins
module pll_phase_stepper
    import pll_phase_stepper_pkg::*;
#(
    parameter int STEP_W       = 8,
    parameter int SETUP_CYC    = 4,
    parameter int PULSE_CYC    = 4,
    parameter int SETTLE_CYC   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int PHASE_MOD    = 48,
    parameter int POS_W        = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_sel,
    input  logic                     req_dir,
    input  logic [STEP_W-1:0]        req_steps,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [4*POS_W-1:0]       phase_pos,
    input  logic                     pll_locked,
    output logic [1:0]               pll_phasesel,
    output logic                     pll_phasedir,
    output logic                     pll_phasestep
);

    localparam int CNT_MAX = max_int(max_int(SETUP_CYC, PULSE_CYC),
                                     max_int(SETTLE_CYC, LOCK_TIMEOUT));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [POS_W-1:0] POS_LAST     = POS_W'(PHASE_MOD - 1);

    state_e              state, next_state;
    logic [CNT_W-1:0]    cnt;
    logic [STEP_W-1:0]   remaining;
    logic [POS_W-1:0]    pos_q [NUM_OUTPUTS];
    logic [POS_W-1:0]    cur_pos, next_pos;
    logic                lock_lost, timed_out;
    logic                lock_synced, lock_stable;
    logic                accept, pulse_end, timeout_hit, stepping;

    lock_sync_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock (
        .clock    (clock),
        .reset    (reset),
        .async_in (pll_locked),
        .clr      (state != ST_WAIT_LOCK),
        .synced   (lock_synced),
        .stable   (lock_stable)
    );

    // Holding ready low during the done cycle keeps a request that was held
    // through busy from being taken before done has pulsed.
    assign req_ready   = (state == ST_IDLE) && !done;
    assign accept      = req_valid && req_ready;
    assign stepping    = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_SETTLE);
    assign pulse_end   = (state == ST_PULSE) && (cnt == PULSE_LAST);
    assign timeout_hit = (state == ST_WAIT_LOCK) && !lock_stable && (cnt == TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:      if (accept) next_state = (req_steps == '0) ? ST_DONE : ST_SETUP;
            ST_SETUP:     if (cnt == SETUP_LAST) next_state = ST_PULSE;
            ST_PULSE:     if (cnt == PULSE_LAST) next_state = ST_SETTLE;
            // remaining was already decremented at the end of the pulse.
            ST_SETTLE:    if (cnt == SETTLE_LAST)
                              next_state = (remaining == '0) ? ST_WAIT_LOCK : ST_PULSE;
            ST_WAIT_LOCK: if (lock_stable || cnt == TIMEOUT_LAST) next_state = ST_DONE;
            ST_DONE:      next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Modular step of the selected output's offset.
    always_comb begin
        cur_pos  = pos_q[pll_phasesel];
        next_pos = cur_pos;
        if (pll_phasedir == DIR_LAG) next_pos = (cur_pos == POS_LAST) ? '0 : cur_pos + POS_W'(1);
        else                         next_pos = (cur_pos == '0) ? POS_LAST : cur_pos - POS_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= '0;
            remaining     <= '0;
            lock_lost     <= 1'b0;
            timed_out     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            pll_phasesel  <= SEL_CLKOP;
            pll_phasedir  <= DIR_LAG;
            pll_phasestep <= 1'b1;
            // NOTE: the offset table is reset along with everything else: the
            // owner resets the PLL too, so stale offsets would be wrong.
            for (int i = 0; i < NUM_OUTPUTS; i++) pos_q[i] <= '0;
        end else begin
            // Shared counter: cycles spent in the current state, 0 on entry.
            if (next_state != state || state == ST_IDLE || state == ST_DONE) cnt <= '0;
            else                                                           cnt <= cnt + CNT_W'(1);

            // Registered from next_state so PHASESTEP is glitch-free and
            // aligned with the PULSE state.
            pll_phasestep <= (next_state != ST_PULSE);

            done <= (state == ST_DONE);
            err  <= (state == ST_DONE) && (lock_lost || timed_out);

            if (accept) begin
                busy         <= 1'b1;
                pll_phasesel <= req_sel;
                pll_phasedir <= req_dir;
                remaining    <= req_steps;
                lock_lost    <= 1'b0;
                timed_out    <= 1'b0;
            end else begin
                if (state == ST_DONE)           busy      <= 1'b0;
                if (stepping && !lock_synced)   lock_lost <= 1'b1;
                if (timeout_hit)                timed_out <= 1'b1;
                if (pulse_end) begin
                    remaining             <= remaining - STEP_W'(1);
                    pos_q[pll_phasesel]   <= next_pos;
                end
            end
        end
    end

    always_comb begin
        phase_pos = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) phase_pos[i*POS_W +: POS_W] = pos_q[i];
    end

endmodule
